timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 16, counter and bus width (legal 4..32)
- NUM_CH, 4, number of independent channels (legal 1..8)
- CH_BITS, 2, channel-select width; SHALL equal max(1, clog2(NUM_CH))
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, system clock; all state changes on rising edge
- reset, in, 1, asynchronous active-high reset
- DATA, in, DATA_WIDTH, bus value loaded into the selected channel
- timer_in, in, 1, load strobe for channel ch_select
- ch_select, in, CH_BITS, channel addressed by timer_in and auto_reload
- auto_reload, in, 1, mode sampled with timer_in: 1 = periodic, 0 = one-shot
- count_en, in, 1, global decrement enable (tick)
- ack, in, 1, clear strobe for the sticky flags of channel ack_select
- ack_select, in, CH_BITS, channel addressed by ack
- REG_OUT_TIMER, out, NUM_CH*DATA_WIDTH, current counts; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- timeout, out, NUM_CH, per-channel sticky expiry flag
- overrun, out, NUM_CH, per-channel sticky flag: expiry while timeout already set
- irq, out, 1, OR of all timeout bits (combinational from registered flags)

Function
REQ-003 Each channel SHALL hold: count, reload value, mode bit, state in {IDLE, RUN, EXPIRED}, timeout, overrun.
REQ-004 Load: timer_in=1 with nonzero DATA SHALL, at that edge, set count=DATA and reload=DATA, latch mode, clear timeout and overrun, and enter RUN.
REQ-005 Load with DATA=0 SHALL set count=0 and reload=0, clear timeout and overrun, and enter IDLE.
REQ-006 ch_select >= NUM_CH with timer_in=1 SHALL be ignored; ack_select >= NUM_CH with ack=1 SHALL be ignored.
REQ-007 In RUN with count_en=1 and count>1, count SHALL decrement by 1 per edge.
REQ-008 In RUN with count_en=1 and count==1, expiry SHALL occur at that edge:
- one-shot: count becomes 0, state becomes EXPIRED
- periodic: count becomes reload, state stays RUN
- both modes: timeout set to 1; if timeout was already 1 before the edge, overrun also set to 1
REQ-009 Latency: load at edge k with value N and count_en held high SHALL cause timeout visible after edge k+N; the first decrement occurs at edge k+1.
REQ-010 IDLE and EXPIRED SHALL hold count constant regardless of count_en; count_en=0 SHALL freeze every channel.
REQ-011 ack=1 SHALL clear timeout and overrun of ack_select at that edge; state and count are unaffected.
REQ-012 Simultaneous events, same channel, same edge:
- load + decrement or expiry: load wins
- load + ack: load result
- ack + expiry: expiry wins; timeout stays 1, overrun not set by this expiry
REQ-013 Channels SHALL be fully independent; a load or ack on one channel SHALL NOT alter any other channel.
REQ-014 Arithmetic SHALL be unsigned modulo 2^DATA_WIDTH; count never decrements below 0 (no wrap).

Reset
REQ-015 reset=1 SHALL immediately, without a clock edge, set every count, reload, mode, timeout and overrun to 0, set every state to IDLE, and drive irq=0.
REQ-016 Reset asserted mid-count SHALL abort the count; after release, the channel stays IDLE until the next nonzero load.
REQ-017 Inputs SHALL be ignored while reset=1; the first edge after release may load.

Verification
REQ-018 Ch0 one-shot, load 5, count_en=1 -> REG_OUT_TIMER[0] shows 5,4,3,2,1,0; timeout[0]=1 after edge k+5 and stays 1; count holds 0; irq=1.
REQ-019 Ch1 periodic, load 3, no ack -> timeout[1] after edge k+3, count reloads 3; at edge k+6 overrun[1]=1; ack ch1 -> both flags 0; counting continues.
REQ-020 Ch2 load 4, count_en toggled 1,0,1,0,... -> count decrements only on enabled edges; expiry after the 4th enabled edge.
REQ-021 Ch3 count==1, ack on ch3 and count_en=1 in the same cycle -> timeout[3]=1 and overrun[3]=0; load 7 on ch0 in the same cycle leaves ch3 untouched.
REQ-022 Reset pulse mid-count on all channels -> all outputs 0 immediately; post-reset count_en=1 with no loads -> counts stay 0 and timeout stays 0.
REQ-023 Load 0 on an expired channel -> timeout cleared, state IDLE; load with ch_select=NUM_CH (when NUM_CH<2^CH_BITS) -> no channel changes.

Source files
------------

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel down-counting timer bank with sticky expiry flags
module timer_bank #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   parameter int CH_BITS    = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        DATA,
   input  logic                         timer_in,
   input  logic [CH_BITS-1:0]           ch_select,
   input  logic                         auto_reload,
   input  logic                         count_en,
   input  logic                         ack,
   input  logic [CH_BITS-1:0]           ack_select,
   output logic [NUM_CH*DATA_WIDTH-1:0] REG_OUT_TIMER,
   output logic [NUM_CH-1:0]            timeout,
   output logic [NUM_CH-1:0]            overrun,
   output logic                         irq
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_e;

   localparam logic [DATA_WIDTH-1:0] CNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] cnt_q    [NUM_CH];
   logic [DATA_WIDTH-1:0] cnt_d    [NUM_CH];
   logic [DATA_WIDTH-1:0] reload_q [NUM_CH];
   logic [DATA_WIDTH-1:0] reload_d [NUM_CH];
   state_e                state_q  [NUM_CH];
   state_e                state_d  [NUM_CH];
   logic [NUM_CH-1:0]     mode_q,    mode_d;
   logic [NUM_CH-1:0]     timeout_q, timeout_d;
   logic [NUM_CH-1:0]     overrun_q, overrun_d;
   logic [NUM_CH-1:0]     load_sel;
   logic [NUM_CH-1:0]     ack_sel;

   // Decode the strobes into one-hot per-channel hits; out-of-range selects hit nothing
   always_comb begin
      load_sel = '0;
      ack_sel  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         load_sel[i] = timer_in && (ch_select == CH_BITS'(i));
         ack_sel[i]  = ack && (ack_select == CH_BITS'(i));
      end
   end

   // Per-channel next state: load dominates, then expiry over ack, then plain decrement
   always_comb begin
      cnt_d     = cnt_q;
      reload_d  = reload_q;
      state_d   = state_q;
      mode_d    = mode_q;
      timeout_d = timeout_q;
      overrun_d = overrun_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (load_sel[i]) begin
            cnt_d[i]     = DATA;
            reload_d[i]  = DATA;
            mode_d[i]    = auto_reload;
            timeout_d[i] = 1'b0;
            overrun_d[i] = 1'b0;
            state_d[i]   = (DATA != '0) ? ST_RUN : ST_IDLE;
         end else begin
            if (ack_sel[i]) begin
               timeout_d[i] = 1'b0;
               overrun_d[i] = 1'b0;
            end
            if (count_en && (state_q[i] == ST_RUN)) begin
               if (cnt_q[i] > CNT_ONE) begin
                  cnt_d[i] = cnt_q[i] - CNT_ONE;
               end else if (cnt_q[i] == CNT_ONE) begin
                  // An ack on the expiry edge keeps the new timeout but suppresses overrun
                  timeout_d[i] = 1'b1;
                  overrun_d[i] = !ack_sel[i] && (overrun_q[i] || timeout_q[i]);
                  if (mode_q[i]) begin
                     cnt_d[i] = reload_q[i];
                  end else begin
                     cnt_d[i]   = '0;
                     state_d[i] = ST_EXPIRED;
                  end
               end
            end
         end
      end
   end

   // State register with asynchronous clear of every channel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= '0;
            reload_q[i] <= '0;
            state_q[i]  <= ST_IDLE;
         end
         mode_q    <= '0;
         timeout_q <= '0;
         overrun_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         reload_q  <= reload_d;
         state_q   <= state_d;
         mode_q    <= mode_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
      end
   end

   // Pack the per-channel counts onto the flat output bus
   always_comb begin
      REG_OUT_TIMER = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         REG_OUT_TIMER[i*DATA_WIDTH +: DATA_WIDTH] = cnt_q[i];
      end
   end

   assign timeout = timeout_q;
   assign overrun = overrun_q;
   assign irq     = |timeout_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - self-checking bench for timer_bank
module tb_timer_bank;

   localparam int DW  = 8;
   localparam int NCH = 5;
   localparam int CB  = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [DW-1:0]   data;
   logic            timer_in;
   logic [CB-1:0]   ch_select;
   logic            auto_reload;
   logic            count_en;
   logic            ack;
   logic [CB-1:0]   ack_select;
   logic [NCH*DW-1:0] reg_out;
   logic [NCH-1:0]  timeout;
   logic [NCH-1:0]  overrun;
   logic            irq;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // Reference model: plain integers and flags per channel
   int m_cnt [NCH];
   int m_rel [NCH];
   bit m_per [NCH];
   bit m_run [NCH];
   bit m_to  [NCH];
   bit m_ov  [NCH];

   always #5 clk = ~clk;

   timer_bank #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CH_BITS(CB)) dut (
      .clk           (clk),
      .reset         (reset),
      .DATA          (data),
      .timer_in      (timer_in),
      .ch_select     (ch_select),
      .auto_reload   (auto_reload),
      .count_en      (count_en),
      .ack           (ack),
      .ack_select    (ack_select),
      .REG_OUT_TIMER (reg_out),
      .timeout       (timeout),
      .overrun       (overrun),
      .irq           (irq)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] cnt_of(input int ch);
      return reg_out[ch*DW +: DW];
   endfunction

   // Model update on each edge, cleared immediately by reset
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_rel[c] = 0; m_per[c] = 0;
            m_run[c] = 0; m_to[c]  = 0; m_ov[c]  = 0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            bit ld, ak, fire;
            ld   = timer_in && (int'(ch_select) == c);
            ak   = ack && (int'(ack_select) == c);
            fire = m_run[c] && count_en && (m_cnt[c] == 1);
            if (ld) begin
               m_cnt[c] = int'(data);
               m_rel[c] = int'(data);
               m_per[c] = auto_reload;
               m_run[c] = (data != 0);
               m_to[c]  = 0;
               m_ov[c]  = 0;
            end else if (fire) begin
               m_ov[c] = ak ? 1'b0 : (m_ov[c] | m_to[c]);
               m_to[c] = 1'b1;
               if (m_per[c]) m_cnt[c] = m_rel[c];
               else begin
                  m_cnt[c] = 0;
                  m_run[c] = 0;
               end
            end else begin
               if (m_run[c] && count_en && m_cnt[c] > 1) m_cnt[c] = m_cnt[c] - 1;
               if (ak) begin
                  m_to[c] = 0;
                  m_ov[c] = 0;
               end
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         bit any_to;
         any_to = 1'b0;
         for (int c = 0; c < NCH; c++) begin
            check($sformatf("model_cnt%0d", c), cnt_of(c), m_cnt[c]);
            check($sformatf("model_timeout%0d", c), timeout[c], m_to[c]);
            check($sformatf("model_overrun%0d", c), overrun[c], m_ov[c]);
            any_to = any_to | m_to[c];
         end
         check("model_irq", irq, any_to);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input int ch, input int val, input bit per);
      ch_select   = CB'(ch);
      data        = DW'(val);
      auto_reload = per;
      timer_in    = 1'b1;
      tick();
      timer_in    = 1'b0;
   endtask

   initial begin
      reset = 1'b1; data = '0; timer_in = 1'b0; ch_select = '0; auto_reload = 1'b0;
      count_en = 1'b0; ack = 1'b0; ack_select = '0;
      @(posedge clk);
      @(negedge clk);
      check("rst_reg_out", reg_out, 0);
      check("rst_timeout", timeout, 0);
      check("rst_overrun", overrun, 0);
      check("rst_irq", irq, 0);
      reset    = 1'b0;
      cmp_en   = 1'b1;
      count_en = 1'b1;

      // Ch0 one-shot load 5
      load(0, 5, 1'b0);
      check("os_load", cnt_of(0), 5);
      for (int j = 1; j <= 5; j++) begin
         tick();
         check($sformatf("os_cnt_k+%0d", j), cnt_of(0), 5 - j);
         check($sformatf("os_to_k+%0d", j), timeout[0], (j == 5) ? 1 : 0);
      end
      check("os_irq", irq, 1);
      tick(); tick();
      check("os_hold_cnt", cnt_of(0), 0);
      check("os_hold_to", timeout[0], 1);

      // Ch1 periodic load 3
      load(1, 3, 1'b1);
      check("per_load", cnt_of(1), 3);
      for (int j = 1; j <= 6; j++) begin
         tick();
         check($sformatf("per_cnt_k+%0d", j), cnt_of(1), (j % 3 == 0) ? 3 : 3 - (j % 3));
         check($sformatf("per_to_k+%0d", j), timeout[1], (j >= 3) ? 1 : 0);
         check($sformatf("per_ov_k+%0d", j), overrun[1], (j >= 6) ? 1 : 0);
      end
      ack = 1'b1; ack_select = 3'd1;
      tick();
      ack = 1'b0;
      check("per_ack_cnt", cnt_of(1), 2);
      check("per_ack_to", timeout[1], 0);
      check("per_ack_ov", overrun[1], 0);
      tick();
      check("per_cont_cnt", cnt_of(1), 1);

      // Ch2 one-shot load 4 with count_en toggling
      load(2, 4, 1'b0);
      for (int j = 0; j < 8; j++) begin
         count_en = (j % 2 == 0);
         tick();
         check($sformatf("tog_cnt_%0d", j), cnt_of(2), 3 - j / 2);
         check($sformatf("tog_to_%0d", j), timeout[2], (j >= 6) ? 1 : 0);
      end
      count_en = 1'b1;

      // Ch3 periodic 1: ack coinciding with expiry, plus load on ch0 the same edge
      load(3, 1, 1'b1);
      check("ae_load", cnt_of(3), 1);
      tick();
      check("ae_first_to", timeout[3], 1);
      check("ae_first_ov", overrun[3], 0);
      ack = 1'b1; ack_select = 3'd3;
      timer_in = 1'b1; ch_select = 3'd0; data = 8'd7; auto_reload = 1'b0;
      tick();
      ack = 1'b0; timer_in = 1'b0;
      check("ae_to", timeout[3], 1);
      check("ae_ov", overrun[3], 0);
      check("ae_cnt3", cnt_of(3), 1);
      check("ae_ch0_cnt", cnt_of(0), 7);
      check("ae_ch0_to", timeout[0], 0);
      tick();
      check("ae_next_ov", overrun[3], 1);
      ack = 1'b1; ack_select = 3'd7;
      tick();
      ack = 1'b0;
      check("oor_ack_ov3", overrun[3], 1);
      check("oor_ack_to3", timeout[3], 1);

      // Ch4: load 0 on an expired channel, then out-of-range loads
      load(4, 3, 1'b0);
      tick(); tick(); tick();
      check("z_exp_to", timeout[4], 1);
      load(4, 0, 1'b0);
      check("z_to", timeout[4], 0);
      check("z_cnt", cnt_of(4), 0);
      tick();
      check("z_idle_cnt", cnt_of(4), 0);
      load(5, 9, 1'b1);
      load(6, 9, 1'b1);
      load(7, 9, 1'b0);
      check("oor_cnt4", cnt_of(4), 0);
      check("oor_to4", timeout[4], 0);

      // Reset pulse mid-count
      load(1, 50, 1'b1);
      load(2, 50, 1'b0);
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_reg_out", reg_out, 0);
      check("mid_rst_timeout", timeout, 0);
      check("mid_rst_overrun", overrun, 0);
      check("mid_rst_irq", irq, 0);
      timer_in = 1'b1; ch_select = 3'd0; data = 8'd5;
      tick();
      check("rst_ignore_load", reg_out, 0);
      timer_in = 1'b0;
      reset = 1'b0;
      tick(); tick(); tick();
      check("post_rst_cnt", reg_out, 0);
      check("post_rst_to", timeout, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
